// File: rtl/alu_operand_loader_if.sv
// ---------------------------------------------------------------------------
// alu_operand_loader_if : switch/button inputs and registered ALU operand outputs
// Revision: 1.0
// ---------------------------------------------------------------------------
`default_nettype none

interface alu_operand_loader_if;
    logic [3:0] sw_data;
    logic [2:0] sw_mod;
    logic       btn_next;
    logic       btn_clr;
    logic [3:0] o_a;
    logic [3:0] o_b;
    logic [2:0] o_mod;
    logic       o_valid;
    logic [1:0] o_state;

    modport master (
        output sw_data, sw_mod, btn_next, btn_clr,
        input  o_a, o_b, o_mod, o_valid, o_state
    );

    modport slave (
        input  sw_data, sw_mod, btn_next, btn_clr,
        output o_a, o_b, o_mod, o_valid, o_state
    );
endinterface

`default_nettype wire

// File: rtl/alu_operand_loader.sv
// ---------------------------------------------------------------------------
// alu_operand_loader : debounced two-button FSM capturing ALU operands A, B, mode
// Revision: 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module alu_operand_loader #(
    parameter int DEBOUNCE_CYC = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    alu_operand_loader_if.slave  bus
);

    localparam int                 c_cnt_w   = (DEBOUNCE_CYC > 1) ? $clog2(DEBOUNCE_CYC) : 1;
    localparam logic [c_cnt_w-1:0] c_cnt_max = c_cnt_w'(DEBOUNCE_CYC - 1);

    typedef enum logic [1:0] {
        S_A   = 2'd0,
        S_B   = 2'd1,
        S_OP  = 2'd2,
        S_RUN = 2'd3
    } state_e;

    // bit 0 = next, bit 1 = clear
    logic [1:0] w_btn_raw;
    logic [1:0] w_pulse;

    assign w_btn_raw = {bus.btn_clr, bus.btn_next};

    for (genvar gi = 0; gi < 2; gi++) begin : g_btn
        logic               sync1_q;
        logic               sync2_q;
        logic               db_q;
        logic               db_d;
        logic               db_dly_q;
        logic [c_cnt_w-1:0] cnt_q;
        logic [c_cnt_w-1:0] cnt_d;

        // Level must disagree with the debounced value for DEBOUNCE_CYC cycles to flip it
        always_comb begin
            db_d  = db_q;
            cnt_d = cnt_q;
            if (sync2_q == db_q) begin
                cnt_d = '0;
            end else if (cnt_q == c_cnt_max) begin
                db_d  = sync2_q;
                cnt_d = '0;
            end else begin
                cnt_d = cnt_q + c_cnt_w'(1);
            end
        end

        always_ff @(posedge clk) begin
            if (rst) begin
                sync1_q  <= 1'b0;
                sync2_q  <= 1'b0;
                db_q     <= 1'b0;
                db_dly_q <= 1'b0;
                cnt_q    <= '0;
            end else begin
                sync1_q  <= w_btn_raw[gi];
                sync2_q  <= sync1_q;
                db_q     <= db_d;
                db_dly_q <= db_q;
                cnt_q    <= cnt_d;
            end
        end

        assign w_pulse[gi] = db_q & ~db_dly_q;
    end

    state_e     state_q, state_d;
    logic [3:0] a_q, a_d;
    logic [3:0] b_q, b_d;
    logic [2:0] mod_q, mod_d;
    logic       valid_q, valid_d;

    // Clear takes priority over a coincident next pulse
    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        mod_d   = mod_q;
        valid_d = valid_q;
        if (w_pulse[1]) begin
            state_d = S_A;
            a_d     = '0;
            b_d     = '0;
            mod_d   = '0;
            valid_d = 1'b0;
        end else if (w_pulse[0]) begin
            case (state_q)
                S_A: begin
                    state_d = S_B;
                    a_d     = bus.sw_data;
                end
                S_B: begin
                    state_d = S_OP;
                    b_d     = bus.sw_data;
                end
                S_OP: begin
                    state_d = S_RUN;
                    mod_d   = bus.sw_mod;
                    valid_d = 1'b1;
                end
                default: begin
                    state_d = S_A;
                    valid_d = 1'b0;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_A;
            a_q     <= '0;
            b_q     <= '0;
            mod_q   <= '0;
            valid_q <= 1'b0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            mod_q   <= mod_d;
            valid_q <= valid_d;
        end
    end

    assign bus.o_a     = a_q;
    assign bus.o_b     = b_q;
    assign bus.o_mod   = mod_q;
    assign bus.o_valid = valid_q;
    assign bus.o_state = state_q;

endmodule

`default_nettype wire

// File: tb/tb_alu_operand_loader.sv
// ---------------------------------------------------------------------------
// tb_alu_operand_loader : directed scoreboard bench for alu_operand_loader
// Revision: 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module tb_alu_operand_loader;

    localparam int DB = 4;

    logic clk;
    logic rst;
    int   n_cmp;
    int   n_err;

    alu_operand_loader_if bus ();

    alu_operand_loader #(.DEBOUNCE_CYC(DB)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [3:0] a;
        logic [3:0] b;
        logic [2:0] mod;
        logic       valid;
        logic [1:0] state;
    } exp_t;

    exp_t sb[$];

    logic [3:0] m_a;
    logic [3:0] m_b;
    logic [2:0] m_mod;
    logic       m_valid;
    logic [1:0] m_state;

    function automatic void model_clr();
        m_a = 4'h0; m_b = 4'h0; m_mod = 3'h0; m_valid = 1'b0; m_state = 2'd0;
    endfunction

    function automatic void model_next(input logic [3:0] d, input logic [2:0] m);
        case (m_state)
            2'd0: begin m_a = d; m_state = 2'd1; end
            2'd1: begin m_b = d; m_state = 2'd2; end
            2'd2: begin m_mod = m; m_valid = 1'b1; m_state = 2'd3; end
            default: begin m_valid = 1'b0; m_state = 2'd0; end
        endcase
    endfunction

    task automatic push_exp();
        exp_t e;
        e.a = m_a; e.b = m_b; e.mod = m_mod; e.valid = m_valid; e.state = m_state;
        sb.push_back(e);
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic check_out(input string tag);
        exp_t e;
        if (sb.size() == 0) begin
            chk({tag, "_sb_empty"}, 32'd0, 32'd1);
        end else begin
            e = sb.pop_front();
            chk({tag, "_a"},     32'(bus.o_a),     32'(e.a));
            chk({tag, "_b"},     32'(bus.o_b),     32'(e.b));
            chk({tag, "_mod"},   32'(bus.o_mod),   32'(e.mod));
            chk({tag, "_valid"}, 32'(bus.o_valid), 32'(e.valid));
            chk({tag, "_state"}, 32'(bus.o_state), 32'(e.state));
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Press next with fixed switches, measuring edges from raw rise to the state change
    task automatic press_timed(input string tag, input logic [3:0] d, input logic [2:0] m);
        logic [1:0] prev;
        int         lat;
        bus.sw_data = d;
        bus.sw_mod  = m;
        model_next(d, m);
        push_exp();
        prev = bus.o_state;
        lat  = 99;
        bus.btn_next = 1'b1;
        for (int k = 0; k < 20; k++) begin
            tick(1);
            if (bus.o_state !== prev) begin
                lat = k;
                break;
            end
        end
        chk({tag, "_lat"}, 32'(lat), 32'(DB + 2));
        bus.btn_next = 1'b0;
        tick(DB + 6);
        check_out(tag);
    endtask

    task automatic pulse_btns(input logic nxt, input logic clr, input int hold);
        bus.btn_next = nxt;
        bus.btn_clr  = clr;
        tick(hold);
        bus.btn_next = 1'b0;
        bus.btn_clr  = 1'b0;
        tick(DB + 6);
    endtask

    initial begin
        n_cmp = 0;
        n_err = 0;
        rst          = 1'b1;
        bus.btn_next = 1'b1;
        bus.btn_clr  = 1'b0;
        bus.sw_data  = 4'h0;
        bus.sw_mod   = 3'h0;
        model_clr();

        repeat (2) @(posedge clk);
        #1;
        push_exp();
        check_out("reset");
        rst          = 1'b0;
        bus.btn_next = 1'b0;
        tick(12);
        push_exp();
        check_out("reset_idle");

        press_timed("capA",  4'h3, 3'h0);
        press_timed("capB",  4'hE, 3'h0);
        press_timed("capOp", 4'h0, 3'h1);
        press_timed("wrap",  4'h9, 3'h5);

        // too short to be accepted
        push_exp();
        pulse_btns(1'b1, 1'b0, DB - 1);
        check_out("glitch3");

        bus.sw_data = 4'h7;
        model_next(4'h7, 3'h0);
        push_exp();
        pulse_btns(1'b1, 1'b0, DB);
        check_out("glitch4");

        model_clr();
        push_exp();
        pulse_btns(1'b0, 1'b1, 8);
        check_out("clr");

        bus.sw_data = 4'h5;
        model_next(4'h5, 3'h0);
        push_exp();
        pulse_btns(1'b1, 1'b0, 50);
        check_out("hold50");
        press_timed("rearm", 4'h6, 3'h0);

        model_clr();
        push_exp();
        pulse_btns(1'b0, 1'b1, 8);
        check_out("clr2");
        press_timed("runA",  4'h3, 3'h0);
        press_timed("runB",  4'hE, 3'h0);
        press_timed("runOp", 4'h0, 3'h1);

        model_clr();
        push_exp();
        pulse_btns(1'b1, 1'b1, 8);
        check_out("clr_prio");
        tick(20);
        push_exp();
        check_out("clr_prio_idle");

        // reset mid-sequence with a partly counted press
        press_timed("preRst", 4'h4, 3'h0);
        bus.btn_next = 1'b1;
        tick(2);
        rst = 1'b1;
        tick(1);
        rst          = 1'b0;
        bus.btn_next = 1'b0;
        model_clr();
        push_exp();
        check_out("rst_mid");
        tick(12);
        push_exp();
        check_out("rst_mid_idle");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

`default_nettype wire
